// File: rtl/rv32_pkg.sv
// rv32_pkg
// Shared definitions for the RV32IM integer register-file write path:
// register-address width, register count, data width and the state
// encoding of the write-port arbiter.
// No ports (package).

package rv32_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int XLEN       = 32;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WAIT = 2'd1,
        ARB_HOLD = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard
// Destination scoreboard for the multi-cycle mul/div unit. Keeps one pending
// bit per architectural register plus a count of operations in flight, so
// the hazard unit can stall readers of a register whose MDU result has not
// been written back yet.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   issue_valid/rd  MDU operation leaving EX and its destination
//   issue_ready     issue accepted (destination free and a slot available)
//   consume/rd      MDU result written to the register file this cycle
//   rs1, rs2        ID-stage source registers
//   busy_rs1/rs2    source still waits for an MDU result
//   consume_stale   result written for a destination that was not pending

module rf_scoreboard
    import rv32_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic                  issue_ready,
    input  logic                  consume,
    input  logic [REG_ADDR_W-1:0] consume_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  busy_rs1,
    output logic                  busy_rs2,
    output logic                  consume_stale
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [NUM_REGS-1:0] pending;
    logic [CNT_W-1:0]    count;
    logic                issue_acc;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    // pending[0] is never set, so an x0 issue is only limited by the slot count
    assign issue_ready   = !pending[issue_rd] && (count < CNT_W'(MAX_OUTSTANDING));
    assign issue_acc     = issue_valid && issue_ready;
    assign busy_rs1      = pending[rs1] && (rs1 != '0);
    assign busy_rs2      = pending[rs2] && (rs2 != '0);
    assign consume_stale = consume && (consume_rd != '0) && !pending[consume_rd];

    // A set and a clear never hit the same register in one cycle because a
    // pending destination blocks its own re-issue.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_acc && (issue_rd != '0)) begin
            set_mask[issue_rd] = 1'b1;
        end
        if (consume) begin
            clr_mask[consume_rd] = 1'b1;
        end
    end

    // The count never wraps below zero, even on a stray (erroneous) result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
            count   <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
            if (issue_acc && !consume) begin
                count <= count + CNT_W'(1);
            end else if (!issue_acc && consume && (count != '0)) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Merges the in-order WB-stage write and the out-of-order MDU result onto the
// single register-file write port (WE3/A3/WD3). WB always wins outside HOLD;
// with the starvation guard built in, an MDU result blocked for STARVE_LIMIT
// consecutive cycles forces a one-cycle pipeline hold in which it is written.
// Build option: define RF_ARB_STARVE_GUARD_EN to build the starve counter and
// the HOLD state; otherwise hold_o is tied low and the MDU simply waits.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   wb_we/wb_rd/wb_wd             WB stage write request
//   mdu_issue_valid/rd/ready      MDU issue handshake (scoreboard)
//   mdu_res_valid/rd/wd/ready     MDU result handshake
//   rs1, rs2 / busy_rs1, busy_rs2 ID-stage hazard lookups
//   hold_o                        pipeline freeze (registered state)
//   rf_we/rf_a3/rf_wd             register-file write port
//   err_o                         sticky protocol-error flag

module rf_wb_arbiter
    import rv32_pkg::*;
#(
    parameter int STARVE_LIMIT    = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_wd,
    input  logic                  mdu_issue_valid,
    input  logic [REG_ADDR_W-1:0] mdu_issue_rd,
    output logic                  mdu_issue_ready,
    input  logic                  mdu_res_valid,
    input  logic [REG_ADDR_W-1:0] mdu_res_rd,
    input  logic [XLEN-1:0]       mdu_res_wd,
    output logic                  mdu_res_ready,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  busy_rs1,
    output logic                  busy_rs2,
    output logic                  hold_o,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_a3,
    output logic [XLEN-1:0]       rf_wd,
    output logic                  err_o
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
        $error("rf_wb_arbiter: STARVE_LIMIT must be 1..15");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 4) begin : g_bad_max_outstanding
        $error("rf_wb_arbiter: MAX_OUTSTANDING must be 1..4");
    end

    arb_state_t state;
    arb_state_t state_nxt;
    logic       wb_active;
    logic       grant;
    logic       consume;
    logic       consume_stale;

    // A WB write to x0 is not a real write, so it does not block the MDU.
    assign wb_active = wb_we && (wb_rd != '0);

`ifdef RF_ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt;
    logic [3:0] starve_nxt;
    logic [3:0] starve_inc;

    // starve_inc is the length of the blocked streak including this cycle;
    // reaching the limit here makes the next cycle the HOLD cycle.
    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        grant      = 1'b0;
        starve_inc = ((state == ARB_WAIT) ? starve_cnt : 4'd0) + 4'd1;
        unique case (state)
            ARB_IDLE, ARB_WAIT: begin
                grant = mdu_res_valid && !wb_active;
                if (mdu_res_valid && wb_active) begin
                    if (starve_inc == 4'(STARVE_LIMIT)) begin
                        state_nxt  = ARB_HOLD;
                        starve_nxt = 4'd0;
                    end else begin
                        state_nxt  = ARB_WAIT;
                        starve_nxt = starve_inc;
                    end
                end else begin
                    state_nxt  = ARB_IDLE;
                    starve_nxt = 4'd0;
                end
            end
            ARB_HOLD: begin
                grant      = 1'b1;
                state_nxt  = ARB_IDLE;
                starve_nxt = 4'd0;
            end
            default: begin
                state_nxt  = ARB_IDLE;
                starve_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ARB_IDLE;
            starve_cnt <= 4'd0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    assign hold_o = (state == ARB_HOLD);
`else
    // Without the guard the MDU waits in ARB_WAIT for a WB-free cycle.
    always_comb begin
        state_nxt = state;
        grant     = mdu_res_valid && !wb_active;
        if (mdu_res_valid && wb_active) begin
            state_nxt = ARB_WAIT;
        end else begin
            state_nxt = ARB_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign hold_o = 1'b0;
`endif

    // Write mux. Writes and result consumption are suppressed while reset is
    // asserted so nothing reaches the register file during reset.
    always_comb begin
        rf_we         = wb_active;
        rf_a3         = wb_rd;
        rf_wd         = wb_wd;
        mdu_res_ready = 1'b0;
        if (grant) begin
            rf_we         = (mdu_res_rd != '0);
            rf_a3         = mdu_res_rd;
            rf_wd         = mdu_res_wd;
            mdu_res_ready = 1'b1;
        end
        if (!rst) begin
            rf_we         = 1'b0;
            mdu_res_ready = 1'b0;
        end
    end

    assign consume = mdu_res_valid && mdu_res_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_o <= 1'b0;
        end else if (consume_stale || (hold_o && !mdu_res_valid)) begin
            err_o <= 1'b1;
        end
    end

    rf_scoreboard #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (mdu_issue_valid),
        .issue_rd     (mdu_issue_rd),
        .issue_ready  (mdu_issue_ready),
        .consume      (consume),
        .consume_rd   (mdu_res_rd),
        .rs1          (rs1),
        .rs2          (rs2),
        .busy_rs1     (busy_rs1),
        .busy_rs2     (busy_rs2),
        .consume_stale(consume_stale)
    );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter
// Directed testbench for rf_wb_arbiter with a behavioural reference model.
// Inputs change 1 ns after each rising edge; the model advances on the rising
// edge and a compare process checks every output on the falling edge.
// Follows RF_ARB_STARVE_GUARD_EN the same way the design does.

`timescale 1ns/100ps

module tb_rf_wb_arbiter;
    import rv32_pkg::*;

    localparam int STARVE_LIMIT    = 4;
    localparam int MAX_OUTSTANDING = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_wd = '0;
    logic        mdu_issue_valid = 1'b0;
    logic [4:0]  mdu_issue_rd = '0;
    logic        mdu_res_valid = 1'b0;
    logic [4:0]  mdu_res_rd = '0;
    logic [31:0] mdu_res_wd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic        mdu_issue_ready;
    logic        mdu_res_ready;
    logic        busy_rs1;
    logic        busy_rs2;
    logic        hold_o;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic        err_o;

    int check_count = 0;
    int pass_count  = 0;

    // Reference model state: which registers await an MDU result, how many
    // operations are in flight, the current blocked streak, whether this
    // cycle is a forced hold, and the sticky error.
    bit [31:0] m_pending;
    int        m_count;
    int        m_streak;
    bit        m_hold;
    bit        m_err;

    always #5 clk = ~clk;

    rf_wb_arbiter #(
        .STARVE_LIMIT   (STARVE_LIMIT),
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wb_we          (wb_we),
        .wb_rd          (wb_rd),
        .wb_wd          (wb_wd),
        .mdu_issue_valid(mdu_issue_valid),
        .mdu_issue_rd   (mdu_issue_rd),
        .mdu_issue_ready(mdu_issue_ready),
        .mdu_res_valid  (mdu_res_valid),
        .mdu_res_rd     (mdu_res_rd),
        .mdu_res_wd     (mdu_res_wd),
        .mdu_res_ready  (mdu_res_ready),
        .rs1            (rs1),
        .rs2            (rs2),
        .busy_rs1       (busy_rs1),
        .busy_rs2       (busy_rs2),
        .hold_o         (hold_o),
        .rf_we          (rf_we),
        .rf_a3          (rf_a3),
        .rf_wd          (rf_wd),
        .err_o          (err_o)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Waits for the next rising edge, drives a new input vector 1 ns later
    // and returns 2 ns after the edge so callers can check combinational
    // outputs for that vector.
    task automatic applyStimulus(input logic we, input logic [4:0] wrd, input logic [31:0] wwd,
                                 input logic iv, input logic [4:0] ird,
                                 input logic rv, input logic [4:0] rrd, input logic [31:0] rwd,
                                 input logic [4:0] r1, input logic [4:0] r2);
        @(posedge clk);
        #1;
        wb_we           = we;
        wb_rd           = wrd;
        wb_wd           = wwd;
        mdu_issue_valid = iv;
        mdu_issue_rd    = ird;
        mdu_res_valid   = rv;
        mdu_res_rd      = rrd;
        mdu_res_wd      = rwd;
        rs1             = r1;
        rs2             = r2;
        #1;
    endtask

    task automatic idleCycle(input logic [4:0] r1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, r1, 5'd0);
    endtask

    // Model step for one clock edge, from the rules: WB wins unless this is a
    // hold cycle; a result blocked STARVE_LIMIT cycles in a row earns a hold.
    task automatic modelStep();
        bit wb_act;
        bit gr;
        bit consumed;
        bit iss_ok;
        wb_act   = wb_we && (wb_rd != 5'd0);
        gr       = m_hold || (mdu_res_valid && !wb_act);
        consumed = gr && mdu_res_valid;
        iss_ok   = mdu_issue_valid && !m_pending[mdu_issue_rd] && (m_count < MAX_OUTSTANDING);
        if (m_hold && !mdu_res_valid) m_err = 1'b1;
        if (consumed && (mdu_res_rd != 5'd0) && !m_pending[mdu_res_rd]) m_err = 1'b1;
        if (consumed) m_pending[mdu_res_rd] = 1'b0;
        if (iss_ok && (mdu_issue_rd != 5'd0)) m_pending[mdu_issue_rd] = 1'b1;
        m_count = m_count + int'(iss_ok) - int'(consumed);
        if (m_count < 0) m_count = 0;
`ifdef RF_ARB_STARVE_GUARD_EN
        if (m_hold) begin
            m_hold   = 1'b0;
            m_streak = 0;
        end else if (mdu_res_valid && wb_act) begin
            m_streak++;
            if (m_streak == STARVE_LIMIT) begin
                m_hold   = 1'b1;
                m_streak = 0;
            end
        end else begin
            m_streak = 0;
        end
`endif
    endtask

    task automatic modelReset();
        m_pending = '0;
        m_count   = 0;
        m_streak  = 0;
        m_hold    = 1'b0;
        m_err     = 1'b0;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) modelReset();
        else      modelStep();
    end

    task automatic compareModel();
        bit          gr;
        bit          e_we;
        logic [4:0]  e_a3;
        logic [31:0] e_wd;
        gr = m_hold || (mdu_res_valid && !(wb_we && (wb_rd != 5'd0)));
        if (gr) begin
            e_we = (mdu_res_rd != 5'd0);
            e_a3 = mdu_res_rd;
            e_wd = mdu_res_wd;
        end else begin
            e_we = wb_we && (wb_rd != 5'd0);
            e_a3 = wb_rd;
            e_wd = wb_wd;
        end
        checkOutput("model.rf_we", 32'(rf_we), 32'(e_we));
        checkOutput("model.rf_a3", 32'(rf_a3), 32'(e_a3));
        checkOutput("model.rf_wd", rf_wd, e_wd);
        checkOutput("model.mdu_res_ready", 32'(mdu_res_ready), 32'(gr));
        checkOutput("model.hold_o", 32'(hold_o), 32'(m_hold));
        checkOutput("model.err_o", 32'(err_o), 32'(m_err));
        checkOutput("model.mdu_issue_ready", 32'(mdu_issue_ready),
                    32'(!m_pending[mdu_issue_rd] && (m_count < MAX_OUTSTANDING)));
        checkOutput("model.busy_rs1", 32'(busy_rs1), 32'(m_pending[rs1] && (rs1 != 5'd0)));
        checkOutput("model.busy_rs2", 32'(busy_rs2), 32'(m_pending[rs2] && (rs2 != 5'd0)));
    endtask

    always @(negedge clk) begin
        if (rst) compareModel();
    end

    initial begin
        // Reset with random inputs: no write, no hold, no error, issue ready.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom),
                          1'($urandom), 5'($urandom), $urandom, 5'($urandom), 5'($urandom));
            checkOutput("reset.rf_we", 32'(rf_we), 32'd0);
            checkOutput("reset.hold_o", 32'(hold_o), 32'd0);
            checkOutput("reset.err_o", 32'(err_o), 32'd0);
            checkOutput("reset.mdu_issue_ready", 32'(mdu_issue_ready), 32'd1);
            checkOutput("reset.mdu_res_ready", 32'(mdu_res_ready), 32'd0);
        end
        wb_we = 1'b0; mdu_issue_valid = 1'b0; mdu_res_valid = 1'b0;
        #1;
        rst = 1'b1;

        for (int i = 0; i < 32; i++) begin
            idleCycle(5'(i));
            checkOutput("post_reset.busy_rs1", 32'(busy_rs1), 32'd0);
        end

        // Free port: issue x5, result three cycles later with WB idle.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
        checkOutput("free.issue_ready", 32'(mdu_issue_ready), 32'd1);
        idleCycle(5'd5);
        checkOutput("free.busy_before", 32'(busy_rs1), 32'd1);
        idleCycle(5'd5);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd5, 32'h0000_002A, 5'd5, 5'd0);
        checkOutput("free.rf_we", 32'(rf_we), 32'd1);
        checkOutput("free.rf_a3", 32'(rf_a3), 32'd5);
        checkOutput("free.rf_wd", rf_wd, 32'h0000_002A);
        checkOutput("free.res_ready", 32'(mdu_res_ready), 32'd1);
        checkOutput("free.busy_write_cycle", 32'(busy_rs1), 32'd1);
        idleCycle(5'd5);
        checkOutput("free.busy_after", 32'(busy_rs1), 32'd0);

        // Contention: WB to x7 wins two cycles, MDU x10 goes in the free one.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 1'b0, 5'd0, 32'h0, 5'd10, 5'd0);
        idleCycle(5'd10);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 5'd7, 32'h0000_0077, 1'b0, 5'd0, 1'b1, 5'd10, 32'hDEAD_BEEF, 5'd10, 5'd0);
            checkOutput("contend.rf_a3_wb", 32'(rf_a3), 32'd7);
            checkOutput("contend.rf_wd_wb", rf_wd, 32'h0000_0077);
            checkOutput("contend.res_ready_low", 32'(mdu_res_ready), 32'd0);
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd10, 32'hDEAD_BEEF, 5'd10, 5'd0);
        checkOutput("contend.rf_a3_mdu", 32'(rf_a3), 32'd10);
        checkOutput("contend.rf_wd_mdu", rf_wd, 32'hDEAD_BEEF);
        checkOutput("contend.res_ready", 32'(mdu_res_ready), 32'd1);
        idleCycle(5'd10);

        // Starvation: WB to x3 every cycle while MDU x11 waits.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 1'b0, 5'd0, 32'h0, 5'd11, 5'd0);
        idleCycle(5'd11);
`ifdef RF_ARB_STARVE_GUARD_EN
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 5'd3, 32'h0000_0033, 1'b0, 5'd0, 1'b1, 5'd11, 32'h0000_0B0B, 5'd11, 5'd0);
            checkOutput("starve.blocked_hold", 32'(hold_o), 32'd0);
            checkOutput("starve.blocked_a3", 32'(rf_a3), 32'd3);
        end
        applyStimulus(1'b1, 5'd3, 32'h0000_0033, 1'b0, 5'd0, 1'b1, 5'd11, 32'h0000_0B0B, 5'd11, 5'd0);
        checkOutput("starve.hold", 32'(hold_o), 32'd1);
        checkOutput("starve.hold_we", 32'(rf_we), 32'd1);
        checkOutput("starve.hold_a3", 32'(rf_a3), 32'd11);
        checkOutput("starve.hold_wd", rf_wd, 32'h0000_0B0B);
        applyStimulus(1'b1, 5'd3, 32'h0000_0033, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd11, 5'd0);
        checkOutput("starve.wb_lands", 32'(rf_a3), 32'd3);
        checkOutput("starve.wb_we", 32'(rf_we), 32'd1);
        checkOutput("starve.hold_released", 32'(hold_o), 32'd0);
        checkOutput("starve.busy_cleared", 32'(busy_rs1), 32'd0);
`else
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 5'd3, 32'h0000_0033, 1'b0, 5'd0, 1'b1, 5'd11, 32'h0000_0B0B, 5'd11, 5'd0);
            checkOutput("starve.no_hold", 32'(hold_o), 32'd0);
            checkOutput("starve.wb_a3", 32'(rf_a3), 32'd3);
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd11, 32'h0000_0B0B, 5'd11, 5'd0);
        checkOutput("starve.mdu_a3", 32'(rf_a3), 32'd11);
        checkOutput("starve.mdu_ready", 32'(mdu_res_ready), 32'd1);
`endif
        idleCycle(5'd0);

        // Scoreboard limits.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
        checkOutput("limit.issue1", 32'(mdu_issue_ready), 32'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
        checkOutput("limit.issue2", 32'(mdu_issue_ready), 32'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
        checkOutput("limit.full", 32'(mdu_issue_ready), 32'd0);
        checkOutput("limit.busy_rs1", 32'(busy_rs1), 32'd1);
        checkOutput("limit.busy_rs2", 32'(busy_rs2), 32'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd2, 32'h0000_2222, 5'd1, 5'd2);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
        checkOutput("limit.reissue_pending", 32'(mdu_issue_ready), 32'd0);
        checkOutput("limit.rs2_freed", 32'(busy_rs2), 32'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        checkOutput("limit.issue_x0", 32'(mdu_issue_ready), 32'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        checkOutput("limit.x0_counts", 32'(mdu_issue_ready), 32'd0);
        checkOutput("limit.x0_not_busy", 32'(busy_rs1), 32'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd1, 32'h0000_1111, 5'd1, 5'd0);
        checkOutput("limit.consume1_a3", 32'(rf_a3), 32'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd0, 32'h0000_0000, 5'd1, 5'd0);
        checkOutput("limit.x0_result_we", 32'(rf_we), 32'd0);
        checkOutput("limit.x0_result_ready", 32'(mdu_res_ready), 32'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 1'b0, 5'd0, 32'h0, 5'd1, 5'd0);
        checkOutput("limit.drained_ready", 32'(mdu_issue_ready), 32'd1);
        checkOutput("limit.no_err", 32'(err_o), 32'd0);

        // Error: result for non-pending x9 sets the sticky flag.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd9, 32'h0000_0999, 5'd0, 5'd0);
        checkOutput("err.before", 32'(err_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            idleCycle(5'd0);
            checkOutput("err.sticky", 32'(err_o), 32'd1);
        end

        // Reset mid-operation with x12 pending drops everything.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 1'b0, 5'd0, 32'h0, 5'd12, 5'd0);
        idleCycle(5'd12);
        checkOutput("midrst.busy_before", 32'(busy_rs1), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("midrst.err_cleared", 32'(err_o), 32'd0);
        checkOutput("midrst.busy_dropped", 32'(busy_rs1), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        idleCycle(5'd12);
        checkOutput("midrst.busy_after", 32'(busy_rs1), 32'd0);
        checkOutput("midrst.issue_ready", 32'(mdu_issue_ready), 32'd1);
        idleCycle(5'd0);

        @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
